calc1_core: RTL and testbench

//  Four-port 32-bit integer calculator. Each port takes a command and two operands serially and

---
 rtl/calc1_core.sv | 175 +++++++++++++++++
 tb/tb_calc1_core.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/calc1_core.sv
// Four-port 32-bit calculator: each port runs an independent two-cycle
// command/operand FSM with registered responses. Optional shifter: CALC1_SHIFT_EN.
module calc1_port #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        cmd_in,
  input  logic [0:DATA_W-1] data_in,
  output logic [0:DATA_W-1] out_data,
  output logic [1:0]        out_resp
);

  typedef enum logic {ST_IDLE = 1'b0, ST_OPND2 = 1'b1} state_t;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  state_t              state_r;
  state_t              state_next_s;
  logic [3:0]          cmd_r;
  logic [DATA_W-1:0]   op1_r;
  logic [DATA_W-1:0]   op2_s;
  logic [DATA_W:0]     sum_s;
  logic [DATA_W-1:0]   res_data_s;
  logic [1:0]          res_resp_s;
  logic                accept_s;

  // Operand vectors are MSB-first; copying to [N-1:0] keeps numeric value.
  assign op2_s    = data_in;
  assign sum_s    = {1'b0, op1_r} + {1'b0, op2_s};
  assign accept_s = (state_r == ST_IDLE) && (cmd_in != 4'd0);

`ifdef CALC1_SHIFT_EN
  logic [SHAMT_W-1:0] shamt_s;
  assign shamt_s = op2_s[SHAMT_W-1:0];
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; cmd_in is only looked at in IDLE
  always_comb begin
    state_next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (cmd_in != 4'd0) begin
          state_next_s = ST_OPND2;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_OPND2: state_next_s = ST_IDLE;
      default:  state_next_s = ST_IDLE;
    endcase
  end

  // Result computation, active only on the operand-2 cycle
  always_comb begin
    res_data_s = {DATA_W{1'b0}};
    res_resp_s = RESP_NONE;
    if (state_r == ST_OPND2) begin
      case (cmd_r)
        4'd1: begin
          if (sum_s[DATA_W]) begin
            res_resp_s = RESP_ERR;
          end else begin
            res_resp_s = RESP_OK;
            res_data_s = sum_s[DATA_W-1:0];
          end
        end
        4'd2: begin
          if (op2_s > op1_r) begin
            res_resp_s = RESP_ERR;
          end else begin
            res_resp_s = RESP_OK;
            res_data_s = op1_r - op2_s;
          end
        end
`ifdef CALC1_SHIFT_EN
        4'd5: begin
          res_resp_s = RESP_OK;
          res_data_s = op1_r << shamt_s;
        end
        4'd6: begin
          res_resp_s = RESP_OK;
          res_data_s = op1_r >> shamt_s;
        end
`endif
        default: begin
          res_resp_s = RESP_ERR;
          res_data_s = {DATA_W{1'b0}};
        end
      endcase
    end else begin
      res_data_s = {DATA_W{1'b0}};
      res_resp_s = RESP_NONE;
    end
  end

  // Request capture and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_r    <= 4'd0;
      op1_r    <= {DATA_W{1'b0}};
      out_data <= {DATA_W{1'b0}};
      out_resp <= RESP_NONE;
    end else begin
      if (accept_s) begin
        cmd_r <= cmd_in;
        op1_r <= data_in;
      end else begin
        cmd_r <= cmd_r;
        op1_r <= op1_r;
      end
      out_data <= res_data_s;
      out_resp <= res_resp_s;
    end
  end

endmodule

module calc1_core #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic [3:0]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [3:0]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [3:0]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [3:0]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [1:0]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [1:0]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [1:0]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [1:0]        out_resp4
);

  calc1_port #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_port1 (
    .clk(c_clk), .rst_n(reset_n), .cmd_in(req1_cmd_in), .data_in(req1_data_in),
    .out_data(out_data1), .out_resp(out_resp1)
  );

  calc1_port #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_port2 (
    .clk(c_clk), .rst_n(reset_n), .cmd_in(req2_cmd_in), .data_in(req2_data_in),
    .out_data(out_data2), .out_resp(out_resp2)
  );

  calc1_port #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_port3 (
    .clk(c_clk), .rst_n(reset_n), .cmd_in(req3_cmd_in), .data_in(req3_data_in),
    .out_data(out_data3), .out_resp(out_resp3)
  );

  calc1_port #(.DATA_W(DATA_W), .SHAMT_W(SHAMT_W)) u_port4 (
    .clk(c_clk), .rst_n(reset_n), .cmd_in(req4_cmd_in), .data_in(req4_data_in),
    .out_data(out_data4), .out_resp(out_resp4)
  );

endmodule

// File: tb/tb_calc1_core.sv
// Directed, table-driven bench for calc1_core; shift expectations follow CALC1_SHIFT_EN.
module tb_calc1_core;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [1:0]  resp;
    logic [31:0] data;
  } vec_t;

  logic        c_clk;
  logic        reset_n;
  logic [3:0]  cmd  [4];
  logic [0:31] din  [4];
  logic [0:31] dout [4];
  logic [1:0]  resp [4];

  int checks;
  int errors;

  calc1_core dut (
    .c_clk(c_clk), .reset_n(reset_n),
    .req1_cmd_in(cmd[0]), .req1_data_in(din[0]),
    .req2_cmd_in(cmd[1]), .req2_data_in(din[1]),
    .req3_cmd_in(cmd[2]), .req3_data_in(din[2]),
    .req4_cmd_in(cmd[3]), .req4_data_in(din[3]),
    .out_data1(dout[0]), .out_resp1(resp[0]),
    .out_data2(dout[1]), .out_resp2(resp[1]),
    .out_data3(dout[2]), .out_resp3(resp[2]),
    .out_data4(dout[3]), .out_resp4(resp[3])
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_port(input string name, input int p, input logic [1:0] er, input logic [31:0] ed);
    check({name, "_resp"}, {30'd0, resp[p]}, {30'd0, er});
    check({name, "_data"}, dout[p], ed);
  endtask

  // One isolated request on port p, then checks the one-cycle response and its clear.
  task automatic run_one(input int p, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed,
                         input string name);
    @(negedge c_clk);
    cmd[p] = c; din[p] = a;
    @(negedge c_clk);
    check_port({name, "_pre"}, p, 2'd0, 32'd0);
    cmd[p] = 4'd1; din[p] = b;
    @(negedge c_clk);
    check_port(name, p, er, ed);
    cmd[p] = 4'd0; din[p] = $urandom;
    @(negedge c_clk);
    check_port({name, "_clr"}, p, 2'd0, 32'd0);
  endtask

  vec_t vec [12];
  logic [1:0]  sh_resp;
  logic [31:0] sh_data;
  logic [31:0] shr_data;
  logic [31:0] shl_data;

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0;
      din[p] = 32'd0;
    end

`ifdef CALC1_SHIFT_EN
    sh_resp  = 2'd1;
    shr_data = 32'h4000_0000;
    shl_data = 32'h0000_0002;
`else
    sh_resp  = 2'd2;
    shr_data = 32'd0;
    shl_data = 32'd0;
`endif
    vec[0]  = '{4'd1,  32'h0000_0001, 32'h1FFF_FFFF, 2'd1, 32'h2000_0000};
    vec[1]  = '{4'd1,  32'hFFFF_FFFF, 32'h0000_0001, 2'd2, 32'd0};
    vec[2]  = '{4'd2,  32'h0000_0001, 32'h0000_000F, 2'd2, 32'd0};
    vec[3]  = '{4'd2,  32'h0000_0010, 32'h0000_0003, 2'd1, 32'h0000_000D};
    vec[4]  = '{4'd2,  32'h0000_0005, 32'h0000_0005, 2'd1, 32'd0};
    vec[5]  = '{4'd3,  32'h0000_0001, 32'h0000_0001, 2'd2, 32'd0};
    vec[6]  = '{4'd4,  32'h0000_0001, 32'h0000_0001, 2'd2, 32'd0};
    vec[7]  = '{4'd15, 32'h1234_5678, 32'h0000_0001, 2'd2, 32'd0};
    vec[8]  = '{4'd6,  32'h8000_0000, 32'h0000_0001, sh_resp, shr_data};
    vec[9]  = '{4'd5,  32'h0000_0001, 32'h0000_0021, sh_resp, shl_data};
    vec[10] = '{4'd1,  32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF};
    vec[11] = '{4'd7,  32'h0000_0009, 32'h0000_0002, 2'd2, 32'd0};

    #1;
    check_port("reset_p1", 0, 2'd0, 32'd0);
    check_port("reset_p4", 3, 2'd0, 32'd0);
    @(negedge c_clk);
    @(negedge c_clk);
    reset_n = 1'b1;

    // Back-to-back table on port 1: one request every two cycles.
    for (int i = 0; i < 12; i++) begin
      @(negedge c_clk);
      if (i > 0) begin
        check_port($sformatf("vec%0d", i - 1), 0, vec[i-1].resp, vec[i-1].data);
      end
      cmd[0] = vec[i].cmd; din[0] = vec[i].op1;
      @(negedge c_clk);
      check_port($sformatf("vec%0d_gap", i), 0, 2'd0, 32'd0);
      cmd[0] = 4'hF; din[0] = vec[i].op2;
    end
    @(negedge c_clk);
    check_port("vec11", 0, vec[11].resp, vec[11].data);
    cmd[0] = 4'd0;
    @(negedge c_clk);
    check_port("vec_end_idle", 0, 2'd0, 32'd0);

    // Shift-left sweep on port 1.
    for (int a = 1; a < 32; a++) begin
`ifdef CALC1_SHIFT_EN
      sh_data = 32'd1 << a;
`else
      sh_data = 32'd0;
`endif
      run_one(0, 4'd5, 32'd1, a, sh_resp, sh_data, $sformatf("shl%0d", a));
    end
    run_one(1, 4'd6, 32'h8000_0000, 32'd1, sh_resp, shr_data, "shr_p2");

    // Idle ports with random data stay silent.
    for (int c = 0; c < 4; c++) begin
      @(negedge c_clk);
      for (int p = 0; p < 4; p++) begin
        cmd[p] = 4'd0; din[p] = $urandom;
      end
      @(posedge c_clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        check_port($sformatf("nop_c%0d_p%0d", c, p + 1), p, 2'd0, 32'd0);
      end
    end

    // Concurrent add on all four ports.
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd1; din[p] = 32'h100 * (p + 1);
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      cmd[p] = 4'd0; din[p] = p + 7;
    end
    @(negedge c_clk);
    check_port("conc_p1", 0, 2'd1, 32'h0000_0107);
    check_port("conc_p2", 1, 2'd1, 32'h0000_0208);
    check_port("conc_p3", 2, 2'd1, 32'h0000_0309);
    check_port("conc_p4", 3, 2'd1, 32'h0000_040A);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      check_port($sformatf("conc_clr_p%0d", p + 1), p, 2'd0, 32'd0);
    end

    // Reset while port 1 shows a response and port 2 waits for operand 2.
    cmd[0] = 4'd1; din[0] = 32'd2;
    @(negedge c_clk);
    cmd[0] = 4'd0; din[0] = 32'd3;
    cmd[1] = 4'd1; din[1] = 32'd4;
    @(negedge c_clk);
    check_port("rst_pre_p1", 0, 2'd1, 32'd5);
    cmd[1] = 4'd0; din[1] = 32'd5;
    reset_n = 1'b0;
    #1;
    check_port("rst_async_p1", 0, 2'd0, 32'd0);
    check_port("rst_async_p2", 1, 2'd0, 32'd0);
    @(negedge c_clk);
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge c_clk);
      check_port($sformatf("rst_post%0d_p2", c), 1, 2'd0, 32'd0);
      check_port($sformatf("rst_post%0d_p1", c), 0, 2'd0, 32'd0);
    end
    run_one(1, 4'd2, 32'd9, 32'd4, 2'd1, 32'd5, "after_rst_p2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
